pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit: successor to the single-width fetch PC.
- Generalises address width, adds stall, absolute jump, trap vector and a configurable-depth return-address stack (RAS) for call/return.
- Sits at the head of the fetch stage. `pc` drives instruction memory; control logic from decode/execute drives redirect inputs.

Parameters:
- ADDR_W, 32, PC and target width in bits
- OFF_W, 32, width of signed branch offset (in words)
- RESET_VEC, 0, PC value after reset
- TRAP_VEC, 32'h100, PC value on trap or RAS underflow
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold PC and RAS (trap still honoured)
- branch_sig  in  1  PC-relative branch
- branch_off  in  OFF_W  signed word offset
- jump_sig  in  1  absolute jump
- jump_target  in  ADDR_W  absolute jump address
- call_sig  in  1  with jump_sig: push return address
- ret_sig  in  1  pop RAS into PC
- trap_sig  in  1  redirect to TRAP_VEC
- pc  out  ADDR_W  current PC (registered)
- pc_plus4  out  ADDR_W  pc + 4 (combinational)
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_err  out  1  sticky: RAS overflow or underflow since reset

Behaviour:
- Reset (async assert): pc=RESET_VEC, RAS pointer=0, ras_count=0, ras_err=0. Reset dominates all inputs and takes effect mid-operation immediately. Normal operation resumes on the first posedge after deassert.
- All updates occur on posedge clk. New PC is visible one cycle after inputs are sampled; zero extra latency.
- Next-PC priority, highest first:
  1. trap_sig: pc=TRAP_VEC. Overrides stall. RAS unchanged.
  2. stall: pc and RAS hold; all other inputs ignored.
  3. ret_sig:
     - If ras_count>0: pc=top entry, pop.
     - If empty: pc=TRAP_VEC, ras_err<=1.
  4. jump_sig: pc=jump_target.
     - If call_sig also set: push pc+4 first.
  5. branch_sig: pc = pc + 4 + (sign_extend(branch_off) << 2), truncated modulo 2^ADDR_W.
  6. Otherwise: pc = pc + 4.
- call_sig without jump_sig is ignored.
- Arithmetic:
  - All additions use ADDR_W bits; wrap-around past 2^ADDR_W-1 is silent.
  - branch_off is sign-extended to ADDR_W before the shift.
  - Negative offsets give backward branches.
- RAS:
  - Circular buffer of RAS_DEPTH entries.
  - Push writes at the pointer, then increments it; pop decrements the pointer, then reads.
  - ras_count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry, sets ras_err and leaves ras_count=RAS_DEPTH.
- Simultaneous signals:
  - ret_sig with jump_sig: ret wins, jump is discarded, no push.
  - trap with anything: trap only, no RAS change.
- ras_err is cleared only by rst.
- pc_plus4 is pure combinational from pc.
- No X propagation: the RAS array resets to 0.

Decomposition:
- Shared package pc_pkg:
  - constant PC_INC=4
  - redirect-source enum {SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_RET, SRC_TRAP}, for debug/trace
  - function sext_shift(off) returning the ADDR_W word-to-byte offset
- One natural sub-module: ras_stack (parametrised circular LIFO with push/pop/count/overflow/underflow).
- pc_unit keeps the priority mux and PC register.

Test Plan:
- Reset then 3 idle cycles, RESET_VEC=0 -> pc sequence 0,4,8,12; pc_plus4=16; async rst mid-cycle -> pc=0 before the next edge.
- pc=0x40, branch_sig=1, branch_off=-2 -> pc=0x3C. Then branch_off=3 -> pc=0x3C+4+12=0x4C. Also pc=0xFFFFFFFC with no redirect -> pc wraps to 0.
- pc=0x20, jump_sig+call_sig, jump_target=0x200 -> pc=0x200, ras_count=1. Later ret_sig -> pc=0x24, ras_count=0.
- RAS_DEPTH=4: five nested calls from pc 0x0,0x100,0x200,0x300,0x400 -> ras_err=1, ras_count=4. Four rets return 0x404,0x304,0x204,0x104 (oldest lost). Fifth ret -> pc=0x100 (TRAP_VEC), ras_err stays 1.
- stall=1 for 3 cycles with branch_sig/ret_sig asserted -> pc and ras_count frozen. trap_sig during stall -> pc=0x100 next edge.
- Same cycle: ret_sig+jump_sig+branch_sig with 1 RAS entry 0x50 -> pc=0x50. Same cycle: trap_sig+ret_sig -> pc=0x100, ras_count unchanged.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter unit: increment, redirect
// source tags and the branch-offset scaling helper.
package pc_pkg;

   localparam int PC_INC = 4;
   localparam int MAX_W  = 64;

   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_BRANCH,
      SRC_JUMP,
      SRC_RET,
      SRC_TRAP
   } redirect_src_e;

   // Word offset (already sign-extended to MAX_W) to byte offset; callers
   // keep the low ADDR_W bits, which gives modulo-2^ADDR_W arithmetic.
   function automatic logic [MAX_W-1:0] sext_shift(input logic signed [MAX_W-1:0] off);
      return {off[MAX_W-3:0], 2'b00};
   endfunction

endpackage

// File: rtl/pc_unit_ras.sv
// Circular return-address stack: the oldest entry is overwritten when full,
// and a sticky error flag records any overflow or underflow.
module ras_stack
   import pc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [ADDR_W-1:0]        data_i,
   output logic [ADDR_W-1:0]        top_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     err_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     ptr_q;
   logic [CW-1:0]     count_q;
   logic              err_q;
   logic              full;
   logic              empty;

   assign full    = (count_q == FULL);
   assign empty   = (count_q == '0);
   assign top_o   = mem_q[ptr_q - PTR_ONE];
   assign count_o = count_q;
   assign err_o   = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         ptr_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else if (push_i) begin
         mem_q[ptr_q] <= data_i;
         ptr_q        <= ptr_q + PTR_ONE;
         if (full) err_q   <= 1'b1;
         else      count_q <= count_q + CNT_ONE;
      end else if (pop_i) begin
         // An empty pop leaves the pointer alone so later pushes stay aligned.
         if (empty) begin
            err_q <= 1'b1;
         end else begin
            ptr_q   <= ptr_q - PTR_ONE;
            count_q <= count_q - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: prioritised next-PC selection (trap, stall, return,
// jump/call, branch, sequential) with a return-address stack for call/return.
module pc_unit
   import pc_pkg::*;
#(
   parameter int               ADDR_W    = 32,
   parameter int               OFF_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'('h100),
   parameter int               RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         branch_sig,
   input  logic signed [OFF_W-1:0]      branch_off,
   input  logic                         jump_sig,
   input  logic [ADDR_W-1:0]            jump_target,
   input  logic                         call_sig,
   input  logic                         ret_sig,
   input  logic                         trap_sig,
   output logic [ADDR_W-1:0]            pc,
   output logic [ADDR_W-1:0]            pc_plus4,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_err
);

   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  pc_d;
   logic [ADDR_W-1:0]  ras_top;
   logic [MAX_W-1:0]   off_bytes;
   logic [ADDR_W-1:0]  branch_tgt;
   logic               ras_push;
   logic               ras_pop;
   redirect_src_e      src;

   assign pc         = pc_q;
   assign pc_plus4   = pc_q + ADDR_W'(PC_INC);
   assign off_bytes  = sext_shift(MAX_W'(branch_off));
   assign branch_tgt = pc_plus4 + off_bytes[ADDR_W-1:0];

   always_comb begin
      src      = SRC_SEQ;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      pc_d     = pc_plus4;
      if (trap_sig) begin
         src = SRC_TRAP;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (ret_sig) begin
         src     = SRC_RET;
         ras_pop = 1'b1;
      end else if (jump_sig) begin
         src      = SRC_JUMP;
         ras_push = call_sig;
      end else if (branch_sig) begin
         src = SRC_BRANCH;
      end

      case (src)
         SRC_TRAP:   pc_d = TRAP_VEC;
         SRC_RET:    pc_d = (ras_count != '0) ? ras_top : TRAP_VEC;
         SRC_JUMP:   pc_d = jump_target;
         SRC_BRANCH: pc_d = branch_tgt;
         default:    ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RESET_VEC;
      else     pc_q <= pc_d;
   end

   ras_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .data_i  (pc_plus4),
      .top_o   (ras_top),
      .count_o (ras_count),
      .err_o   (ras_err)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with default parameters (32-bit, RAS depth 4).
module tb_pc_unit;

   logic               clk = 1'b0;
   logic               rst;
   logic               stall;
   logic               branch_sig;
   logic signed [31:0] branch_off;
   logic               jump_sig;
   logic [31:0]        jump_target;
   logic               call_sig;
   logic               ret_sig;
   logic               trap_sig;
   logic [31:0]        pc;
   logic [31:0]        pc_plus4;
   logic [2:0]         ras_count;
   logic               ras_err;

   int checks = 0;
   int errors = 0;

   pc_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .branch_sig  (branch_sig),
      .branch_off  (branch_off),
      .jump_sig    (jump_sig),
      .jump_target (jump_target),
      .call_sig    (call_sig),
      .ret_sig     (ret_sig),
      .trap_sig    (trap_sig),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .ras_count   (ras_count),
      .ras_err     (ras_err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      stall = 0; branch_sig = 0; branch_off = 0; jump_sig = 0; jump_target = 0;
      call_sig = 0; ret_sig = 0; trap_sig = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic do_jump(input logic [31:0] tgt, input logic call);
      jump_sig = 1; jump_target = tgt; call_sig = call;
      step();
      idle();
   endtask

   task automatic do_ret();
      ret_sig = 1;
      step();
      idle();
   endtask

   task automatic test_reset();
      logic [31:0] exp_seq [4];
      exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
      idle();
      rst = 1;
      #3;
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
      checks++; if (ras_count !== 3'd0 || ras_err !== 1'b0) begin errors++; $display("FAIL reset_ras: got count %0d err %b expected 0 0", ras_count, ras_err); end
      step();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pc !== exp_seq[i]) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, exp_seq[i]); end
         if (i < 3) step();
      end
      checks++; if (pc_plus4 !== 32'h10) begin errors++; $display("FAIL seq_pc_plus4: got %h expected %h", pc_plus4, 32'h10); end
      #2 rst = 1;
      #1;
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_reset: got %h expected %h", pc, 32'h0); end
      rst = 0;
   endtask

   task automatic test_branch();
      do_reset();
      do_jump(32'h40, 0);
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL jump_40: got %h expected %h", pc, 32'h40); end
      branch_sig = 1; branch_off = -2;
      step();
      checks++; if (pc !== 32'h3C) begin errors++; $display("FAIL branch_back: got %h expected %h", pc, 32'h3C); end
      branch_off = 3;
      step();
      idle();
      checks++; if (pc !== 32'h4C) begin errors++; $display("FAIL branch_fwd: got %h expected %h", pc, 32'h4C); end
      checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL branch_ras: got %0d expected 0", ras_count); end
   endtask

   task automatic test_wrap();
      do_reset();
      do_jump(32'hFFFF_FFFC, 0);
      checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected %h", pc_plus4, 32'h0); end
      step();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
   endtask

   task automatic test_call_ret();
      do_reset();
      do_jump(32'h20, 0);
      do_jump(32'h200, 1);
      checks++; if (pc !== 32'h200 || ras_count !== 3'd1) begin errors++; $display("FAIL call: got pc %h count %0d expected 200 1", pc, ras_count); end
      step();
      checks++; if (pc !== 32'h204) begin errors++; $display("FAIL after_call: got %h expected %h", pc, 32'h204); end
      do_ret();
      checks++; if (pc !== 32'h24 || ras_count !== 3'd0) begin errors++; $display("FAIL ret: got pc %h count %0d expected 24 0", pc, ras_count); end
      checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL ret_err: got %b expected 0", ras_err); end
   endtask

   task automatic test_stall();
      do_reset();
      do_jump(32'h80, 1);
      stall = 1; branch_sig = 1; branch_off = 5; ret_sig = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (pc !== 32'h80 || ras_count !== 3'd1) begin errors++; $display("FAIL stall[%0d]: got pc %h count %0d expected 80 1", i, pc, ras_count); end
      end
      trap_sig = 1;
      step();
      idle();
      checks++; if (pc !== 32'h100 || ras_count !== 3'd1) begin errors++; $display("FAIL stall_trap: got pc %h count %0d expected 100 1", pc, ras_count); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      do_jump(32'h4C, 0);
      do_jump(32'h300, 1);
      ret_sig = 1; jump_sig = 1; call_sig = 1; jump_target = 32'h700; branch_sig = 1; branch_off = 8;
      step();
      idle();
      checks++; if (pc !== 32'h50 || ras_count !== 3'd0) begin errors++; $display("FAIL ret_jump_branch: got pc %h count %0d expected 50 0", pc, ras_count); end
      do_jump(32'h400, 1);
      trap_sig = 1; ret_sig = 1;
      step();
      idle();
      checks++; if (pc !== 32'h100 || ras_count !== 3'd1) begin errors++; $display("FAIL trap_ret: got pc %h count %0d expected 100 1", pc, ras_count); end
      checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL simul_err: got %b expected 0", ras_err); end
      do_jump(32'h600, 0);
      do_ret();
      checks++; if (pc !== 32'h54) begin errors++; $display("FAIL ras_after_trap: got %h expected %h", pc, 32'h54); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_ret [4];
      exp_ret = '{32'h404, 32'h304, 32'h204, 32'h104};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (pc !== 32'(i * 'h100)) begin errors++; $display("FAIL call_src[%0d]: got %h expected %h", i, pc, 32'(i * 'h100)); end
         do_jump(32'((i + 1) * 'h100), 1);
      end
      checks++; if (ras_count !== 3'd4 || ras_err !== 1'b1) begin errors++; $display("FAIL overflow: got count %0d err %b expected 4 1", ras_count, ras_err); end
      for (int i = 0; i < 4; i++) begin
         do_ret();
         checks++;
         if (pc !== exp_ret[i] || ras_count !== 3'(3 - i)) begin errors++; $display("FAIL pop[%0d]: got pc %h count %0d expected %h %0d", i, pc, ras_count, exp_ret[i], 3 - i); end
      end
      do_ret();
      checks++; if (pc !== 32'h100 || ras_count !== 3'd0) begin errors++; $display("FAIL underflow: got pc %h count %0d expected 100 0", pc, ras_count); end
      checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", ras_err); end
      do_reset();
      checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", ras_err); end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_wrap();
      test_call_ret();
      test_stall();
      test_simultaneous();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
